// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deserializer: bit-ordering selectors and
// the counter-width helper.
package sipo_pkg;

  localparam int unsigned ORDER_LSB_FIRST = 0;
  localparam int unsigned ORDER_MSB_FIRST = 1;

  // Smallest r with 2**r >= v; used to size bit_cnt.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// Word holding register for the deserializer.
// Provides the valid/ready handshake and sticky overrun detection.
module sipo_out_reg
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word,
  input  logic             word_done,
  input  logic             data_ready,
  input  logic             clear,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             transfer;

  always_comb begin
    transfer  = valid_q & data_ready;
    data_d    = data_q;
    valid_d   = valid_q & ~transfer;
    overrun_d = overrun_q;
    // A word completing on the same edge as a transfer takes the freed slot.
    if (word_done) begin
      if (!valid_q || transfer) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (clear) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: gated shift register and word framing
// counter, feeding a handshaked holding register.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    serial_in,
  input  logic                    bit_valid,
  input  logic                    clear,
  output logic [WIDTH-1:0]        q,
  output logic [clog2(WIDTH)-1:0] bit_cnt,
  output logic [WIDTH-1:0]        data_out,
  output logic                    data_valid,
  input  logic                    data_ready,
  output logic                    overrun
);

  localparam int unsigned CW = clog2(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;
  logic             word_done;

  always_comb begin
    if (MSB_FIRST == ORDER_MSB_FIRST) begin
      shifted = {q_q[WIDTH-2:0], serial_in};
    end else begin
      shifted = {serial_in, q_q[WIDTH-1:1]};
    end
    q_d       = q_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    // clear wins over bit_valid, so the bit sampled alongside it is dropped.
    if (clear) begin
      q_d   = '0;
      cnt_d = '0;
    end else if (bit_valid) begin
      q_d = shifted;
      if (cnt_q == CW'(WIDTH - 1)) begin
        cnt_d     = '0;
        word_done = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q       = q_q;
  assign bit_cnt = cnt_q;

  sipo_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .word      (shifted),
    .word_done (word_done),
    .data_ready(data_ready),
    .clear     (clear),
    .data_out  (data_out),
    .data_valid(data_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances driven in parallel,
// words scoreboarded at handshake transfer plus direct state checks.
`timescale 1ns/1ps
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       clear = 1'b0;
  logic       data_ready = 1'b0;

  logic [3:0] m_q, m_dout, l_q, l_dout;
  logic [1:0] m_cnt, l_cnt;
  logic       m_valid, m_ovr, l_valid, l_ovr;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] sb_m[$];
  logic [3:0] sb_l[$];

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
    .clear(clear), .q(m_q), .bit_cnt(m_cnt), .data_out(m_dout),
    .data_valid(m_valid), .data_ready(data_ready), .overrun(m_ovr)
  );

  sipo_deser #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
    .clear(clear), .q(l_q), .bit_cnt(l_cnt), .data_out(l_dout),
    .data_valid(l_valid), .data_ready(data_ready), .overrun(l_ovr)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // Outputs are stable at the falling edge; a valid&ready seen here transfers on the next rise.
  always @(negedge clk) begin
    if (!rst && m_valid && data_ready) begin
      if (sb_m.size() == 0) check("sb_m_underflow", 0, 1);
      else check("sb_m_word", m_dout, sb_m.pop_front());
    end
    if (!rst && l_valid && data_ready) begin
      if (sb_l.size() == 0) check("sb_l_underflow", 0, 1);
      else check("sb_l_word", l_dout, sb_l.pop_front());
    end
  end

  task automatic step(input logic sin, input logic bv, input logic clr, input logic rdy);
    serial_in  = sin;
    bit_valid  = bv;
    clear      = clr;
    data_ready = rdy;
    @(posedge clk);
    #2;
    bit_valid = 1'b0;
    clear     = 1'b0;
  endtask

  // Sends w[3] first; push=1 records the word as one the consumer must receive.
  task automatic send_bits(input logic [3:0] w, input int gap, input logic rdy,
                           input logic rdy_last, input logic push);
    logic [3:0] r;
    for (int i = 3; i >= 0; i--) begin
      if (i != 3) repeat (gap) step(1'b0, 1'b0, 1'b0, rdy);
      if (i == 0 && push) begin
        r = {w[0], w[1], w[2], w[3]};
        sb_m.push_back(w);
        sb_l.push_back(r);
      end
      step(w[i], 1'b1, 1'b0, (i == 0) ? rdy_last : rdy);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("rst_q", m_q, 0);
    check("rst_cnt", m_cnt, 0);
    check("rst_dout", m_dout, 0);
    check("rst_valid", m_valid, 0);
    check("rst_ovr", m_ovr, 0);
    rst = 1'b0;

    // 1: basic word, both orderings
    send_bits(4'b1011, 0, 1'b1, 1'b1, 1'b1);
    check("t1_m_dout", m_dout, 4'b1011);
    check("t1_m_valid", m_valid, 1);
    check("t1_m_cnt", m_cnt, 0);
    check("t1_m_q", m_q, 4'b1011);
    check("t1_l_dout", l_dout, 4'b1101);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_drained", m_valid, 0);

    // 2: idle gaps between bits
    serial_in = 1'b1; bit_valid = 1'b1; data_ready = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_gap_cnt", m_cnt, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    sb_m.push_back(4'b1011);
    sb_l.push_back(4'b1101);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("t2_l_dout", l_dout, 4'b1101);
    check("t2_m_dout", m_dout, 4'b1011);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // 3: overrun while consumer stalls
    send_bits(4'b1011, 0, 1'b0, 1'b0, 1'b1);
    check("t3_ovr_pre", m_ovr, 0);
    send_bits(4'b0110, 0, 1'b0, 1'b0, 1'b0);
    check("t3_dout_kept", m_dout, 4'b1011);
    check("t3_ovr", m_ovr, 1);
    check("t3_l_ovr", l_ovr, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_valid_after_xfer", m_valid, 0);
    check("t3_ovr_sticky", m_ovr, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_ovr_cleared", m_ovr, 0);

    // 4: transfer on the edge that completes the next word
    send_bits(4'b1011, 0, 1'b0, 1'b0, 1'b1);
    send_bits(4'b0110, 0, 1'b0, 1'b1, 1'b1);
    check("t4_valid", m_valid, 1);
    check("t4_dout", m_dout, 4'b0110);
    check("t4_ovr", m_ovr, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // 5: clear drops partial word and the bit beside it, keeps pending word
    send_bits(4'b1010, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_cnt_partial", m_cnt, 2);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("t5_clr_q", m_q, 0);
    check("t5_clr_cnt", m_cnt, 0);
    check("t5_pending_dout", m_dout, 4'b1010);
    check("t5_pending_valid", m_valid, 1);
    send_bits(4'b0011, 0, 1'b1, 1'b1, 1'b1);
    check("t5_m_dout", m_dout, 4'b0011);
    check("t5_l_dout", l_dout, 4'b1100);
    check("t5_ovr", m_ovr, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // 6: asynchronous reset mid-word with a word pending
    send_bits(4'b1001, 0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t6_pre_valid", m_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_q", m_q, 0);
    check("t6_rst_cnt", m_cnt, 0);
    check("t6_rst_dout", m_dout, 0);
    check("t6_rst_valid", m_valid, 0);
    check("t6_rst_ovr", m_ovr, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    send_bits(4'b0101, 0, 1'b1, 1'b1, 1'b1);
    check("t6_m_dout", m_dout, 4'b0101);
    check("t6_l_dout", l_dout, 4'b1010);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    check("sb_m_drain", sb_m.size(), 0);
    check("sb_l_drain", sb_l.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
